// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache request sequencer.
package cache_pkg;
  localparam int unsigned WAYS    = 4;
  localparam int unsigned AGE_W   = 2;
  localparam int unsigned TIMEOUT = 255;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_CHECK,
    S_FETCH,
    S_FILL,
    S_MEM_WRITE,
    S_RESPOND
  } state_e;
endpackage

// File: rtl/cache_lru_select.sv
// Combinational LRU helper: touch masks for a hit way and victim/fill masks for a miss.
module cache_lru_select #(
  parameter int unsigned WAYS  = cache_pkg::WAYS,
  parameter int unsigned AGE_W = cache_pkg::AGE_W
) (
  input  logic [WAYS*AGE_W-1:0] ages,
  input  logic [WAYS-1:0]       hit_set,
  output logic [WAYS-1:0]       touch_reset,
  output logic [WAYS-1:0]       touch_inc,
  output logic [WAYS-1:0]       victim,
  output logic [WAYS-1:0]       fill_inc
);
  logic [AGE_W-1:0] hit_age;
  logic [AGE_W-1:0] max_age;
  logic             hit_found;
  logic             vic_found;

  always_comb begin
    touch_reset = '0;
    touch_inc   = '0;
    victim      = '0;
    hit_age     = '0;
    max_age     = '0;
    hit_found   = 1'b0;
    vic_found   = 1'b0;
    // Lowest set bit of the hit vector is the hit way.
    for (int i = 0; i < int'(WAYS); i++) begin
      if (hit_set[i] && !hit_found) begin
        hit_found      = 1'b1;
        touch_reset[i] = 1'b1;
        hit_age        = ages[i*AGE_W +: AGE_W];
      end
    end
    for (int i = 0; i < int'(WAYS); i++) begin
      if (!touch_reset[i] && (ages[i*AGE_W +: AGE_W] < hit_age)) touch_inc[i] = 1'b1;
      if (ages[i*AGE_W +: AGE_W] > max_age) max_age = ages[i*AGE_W +: AGE_W];
    end
    // Victim is the lowest-index way holding the maximum age.
    for (int i = 0; i < int'(WAYS); i++) begin
      if (!vic_found && (ages[i*AGE_W +: AGE_W] == max_age)) begin
        vic_found = 1'b1;
        victim[i] = 1'b1;
      end
    end
    fill_inc = ~victim;
  end
endmodule

// File: rtl/cache_controller.sv
// Single-request sequencer between a CPU, a 4-way cache and main memory;
// write-through/no-allocate, read misses fill the LRU victim.
module cache_controller #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned WAYS    = cache_pkg::WAYS,
  parameter int unsigned AGE_W   = cache_pkg::AGE_W,
  parameter int unsigned TIMEOUT = cache_pkg::TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic                   cpu_ready,
  output logic                   cpu_done,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_err,
  output logic [ADDR_W-1:0]      address_word,
  output logic                   try_read,
  output logic                   try_write,
  output logic [DATA_W-1:0]      write_data,
  output logic [WAYS-1:0]        reset_age,
  output logic [WAYS-1:0]        increment_age,
  input  logic [DATA_W-1:0]      data,
  input  logic [WAYS*AGE_W-1:0]  ages,
  input  logic                   hit_miss,
  input  logic [WAYS-1:0]        hit_miss_set,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_ack,
  input  logic [DATA_W-1:0]      mem_rdata
);
  import cache_pkg::*;

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic              we_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] fetch_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              hit_c;
  logic [WAYS-1:0]   touch_reset_c;
  logic [WAYS-1:0]   touch_inc_c;
  logic [WAYS-1:0]   victim_c;
  logic [WAYS-1:0]   fill_inc_c;

  assign hit_c = hit_miss && (|hit_miss_set);

  cache_lru_select #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru (
    .ages       (ages),
    .hit_set    (hit_miss_set),
    .touch_reset(touch_reset_c),
    .touch_inc  (touch_inc_c),
    .victim     (victim_c),
    .fill_inc   (fill_inc_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fetch_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_req) begin
            we_q    <= cpu_we;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            err_q   <= 1'b0;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: state_q <= S_CHECK;
        S_CHECK: begin
          cnt_q <= '0;
          if (we_q) begin
            state_q <= S_MEM_WRITE;
          end else if (hit_c) begin
            rdata_q <= data;
            state_q <= S_RESPOND;
          end else begin
            state_q <= S_FETCH;
          end
        end
        // Memory waits share one counter; ack wins over an expiring timeout.
        S_FETCH, S_MEM_WRITE: begin
          if (mem_ack) begin
            if (state_q == S_FETCH) begin
              fetch_q <= mem_rdata;
              state_q <= S_FILL;
            end else begin
              state_q <= S_RESPOND;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_RESPOND;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_FILL: begin
          rdata_q <= fetch_q;
          state_q <= S_RESPOND;
        end
        S_RESPOND: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  // Output decode from registered state; cache-side age masks use same-cycle cache results.
  always_comb begin
    try_write     = 1'b0;
    write_data    = '0;
    reset_age     = '0;
    increment_age = '0;
    if (state_q == S_CHECK && hit_c) begin
      reset_age     = touch_reset_c;
      increment_age = touch_inc_c;
      if (we_q) begin
        try_write  = 1'b1;
        write_data = wdata_q;
      end
    end else if (state_q == S_FILL) begin
      try_write     = 1'b1;
      write_data    = fetch_q;
      reset_age     = victim_c;
      increment_age = fill_inc_c;
    end
  end

  assign cpu_ready    = (state_q == S_IDLE);
  assign cpu_done     = (state_q == S_RESPOND);
  assign cpu_err      = (state_q == S_RESPOND) && err_q;
  assign cpu_rdata    = rdata_q;
  assign address_word = addr_q;
  assign try_read     = (state_q == S_LOOKUP);
  assign mem_req      = (state_q == S_FETCH) || (state_q == S_MEM_WRITE);
  assign mem_we       = (state_q == S_MEM_WRITE);
  assign mem_addr     = mem_req ? addr_q : '0;
  assign mem_wdata    = mem_we ? wdata_q : '0;
endmodule
